// File: rtl/fp_mult_pipe.sv
// Pipelined IEEE-754 multiplier with round-to-nearest-even, flush-to-zero and exception flags.
// Four register ranks (operand capture, classify, multiply, normalise/pack) advance together on adv.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * MAN_W + 2;
  localparam logic [EW2-1:0]   BIAS_X   = EW2'(2 ** (EXP_W - 1) - 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W - 1){1'b0}}};

  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  logic         r0Valid;
  logic [W-1:0] r0A, r0B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0Valid <= 1'b0;
      r0A     <= '0;
      r0B     <= '0;
    end else if (w_adv) begin
      r0Valid <= in_valid;
      if (in_valid) begin
        r0A <= a;
        r0B <= b;
      end
    end
  end

  logic             w_sign;
  logic [EXP_W-1:0] w_expA, w_expB;
  logic [MAN_W-1:0] w_fracA, w_fracB;
  logic             w_zeroA, w_zeroB, w_infA, w_infB, w_nanA, w_nanB, w_snanA, w_snanB, w_invMul;
  logic [EW2-1:0]   w_expSum;

  assign w_sign   = r0A[W-1] ^ r0B[W-1];
  assign w_expA   = r0A[W-2:MAN_W];
  assign w_expB   = r0B[W-2:MAN_W];
  assign w_fracA  = r0A[MAN_W-1:0];
  assign w_fracB  = r0B[MAN_W-1:0];
  assign w_zeroA  = (w_expA == '0);
  assign w_zeroB  = (w_expB == '0);
  assign w_infA   = (w_expA == EXP_ONES) && (w_fracA == '0);
  assign w_infB   = (w_expB == EXP_ONES) && (w_fracB == '0);
  assign w_nanA   = (w_expA == EXP_ONES) && (w_fracA != '0);
  assign w_nanB   = (w_expB == EXP_ONES) && (w_fracB != '0);
  assign w_snanA  = w_nanA && !w_fracA[MAN_W-1];
  assign w_snanB  = w_nanB && !w_fracB[MAN_W-1];
  assign w_invMul = (w_infA && w_zeroB) || (w_zeroA && w_infB);
  assign w_expSum = {2'b00, w_expA} + {2'b00, w_expB} - BIAS_X;

  logic         w_special;
  logic [W-1:0] w_specRes;
  logic [3:0]   w_specFlags;

  // Special-operand outcome, highest priority first; subnormal inputs already count as zero.
  always_comb begin
    w_special   = 1'b0;
    w_specRes   = '0;
    w_specFlags = 4'b0000;
    if (w_nanA || w_nanB || w_invMul) begin
      w_special   = 1'b1;
      w_specRes   = QNAN;
      w_specFlags = {w_invMul || w_snanA || w_snanB, 3'b000};
    end else if (w_infA || w_infB) begin
      w_special = 1'b1;
      w_specRes = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_zeroA || w_zeroB) begin
      w_special = 1'b1;
      w_specRes = {w_sign, {(W - 1){1'b0}}};
    end
  end

  logic             r1Valid, r1Sign, r1Special;
  logic [EW2-1:0]   r1Exp;
  logic [MAN_W:0]   r1ManA, r1ManB;
  logic [W-1:0]     r1SpecRes;
  logic [3:0]       r1SpecFlags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1Valid     <= 1'b0;
      r1Sign      <= 1'b0;
      r1Special   <= 1'b0;
      r1Exp       <= '0;
      r1ManA      <= '0;
      r1ManB      <= '0;
      r1SpecRes   <= '0;
      r1SpecFlags <= '0;
    end else if (w_adv) begin
      r1Valid     <= r0Valid;
      r1Sign      <= w_sign;
      r1Special   <= w_special;
      r1Exp       <= w_expSum;
      r1ManA      <= {1'b1, w_fracA};
      r1ManB      <= {1'b1, w_fracB};
      r1SpecRes   <= w_specRes;
      r1SpecFlags <= w_specFlags;
    end
  end

  logic           r2Valid, r2Sign, r2Special;
  logic [EW2-1:0] r2Exp;
  logic [PW-1:0]  r2Prod;
  logic [W-1:0]   r2SpecRes;
  logic [3:0]     r2SpecFlags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2Valid     <= 1'b0;
      r2Sign      <= 1'b0;
      r2Special   <= 1'b0;
      r2Exp       <= '0;
      r2Prod      <= '0;
      r2SpecRes   <= '0;
      r2SpecFlags <= '0;
    end else if (w_adv) begin
      r2Valid     <= r1Valid;
      r2Sign      <= r1Sign;
      r2Special   <= r1Special;
      r2Exp       <= r1Exp;
      r2Prod      <= PW'(r1ManA) * PW'(r1ManB);
      r2SpecRes   <= r1SpecRes;
      r2SpecFlags <= r1SpecFlags;
    end
  end

  logic             w_msb, w_guard, w_sticky, w_roundUp, w_carry, w_ovf, w_unf;
  logic [PW-1:0]    w_norm;
  logic [MAN_W:0]   w_mant;
  logic [MAN_W+1:0] w_rounded;
  logic [MAN_W-1:0] w_frac;
  logic [EW2-1:0]   w_expFin;

  // Product lies in [1,4); left-align it so mantissa, guard and sticky sit at fixed positions.
  assign w_msb     = r2Prod[PW-1];
  assign w_norm    = w_msb ? r2Prod : {r2Prod[PW-2:0], 1'b0};
  assign w_mant    = w_norm[PW-1:MAN_W+1];
  assign w_guard   = w_norm[MAN_W];
  assign w_sticky  = |w_norm[MAN_W-1:0];
  assign w_roundUp = w_guard && (w_sticky || w_mant[0]);
  assign w_rounded = {1'b0, w_mant} + (MAN_W + 2)'(w_roundUp);
  assign w_carry   = w_rounded[MAN_W+1];
  assign w_frac    = w_carry ? w_rounded[MAN_W:1] : w_rounded[MAN_W-1:0];
  assign w_expFin  = r2Exp + EW2'(w_msb) + EW2'(w_carry);
  assign w_ovf     = !w_expFin[EW2-1] && (w_expFin[EXP_W:0] >= {1'b0, EXP_ONES});
  assign w_unf     = w_expFin[EW2-1] || (w_expFin == '0);

  logic [W-1:0] w_res;
  logic [3:0]   w_flags;

  always_comb begin
    w_res   = {r2Sign, w_expFin[EXP_W-1:0], w_frac};
    w_flags = {3'b000, w_guard || w_sticky};
    if (r2Special) begin
      w_res   = r2SpecRes;
      w_flags = r2SpecFlags;
    end else if (w_ovf) begin
      w_res   = {r2Sign, EXP_ONES, {MAN_W{1'b0}}};
      w_flags = 4'b0101;
    end else if (w_unf) begin
      w_res   = {r2Sign, {(W - 1){1'b0}}};
      w_flags = 4'b0011;
    end
  end

  // Output rank only reloads on adv, so a stalled result and its flags stay put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (w_adv) begin
      out_valid <= r2Valid;
      if (r2Valid) begin
        result <= w_res;
        flags  <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe: directed corner cases, a stalled stream, async reset mid-flight,
// and randomized operands checked against an integer-arithmetic binary32 reference model.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   failures = 0;
  bit   monitorOn = 1'b0;
  bit   randomReady = 1'b0;
  bit   forcedReady = 1'b1;
  bit   sawInReadyLow = 1'b0;

  task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: classify, exact product of significands, round by remainder comparison.
  function automatic exp_t refMul(input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    int ex, ey, k, sh, e;
    logic [22:0] fx, fy;
    logic s;
    bit nanX, nanY, infX, infY, zX, zY, badMul;
    longint p, q, rem, half;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = x[22:0];
    fy = y[22:0];
    nanX = (ex == 255) && (fx != 0);
    nanY = (ey == 255) && (fy != 0);
    infX = (ex == 255) && (fx == 0);
    infY = (ey == 255) && (fy == 0);
    zX = (ex == 0);
    zY = (ey == 0);
    badMul = (infX && zY) || (zX && infY);
    r.res = 32'h0;
    r.fl  = 4'b0000;
    if (nanX || nanY || badMul) begin
      r.res = 32'h7FC00000;
      r.fl  = {badMul || (nanX && !fx[22]) || (nanY && !fy[22]), 3'b000};
    end else if (infX || infY) begin
      r.res = {s, 8'hFF, 23'd0};
    end else if (zX || zY) begin
      r.res = {s, 31'd0};
    end else begin
      p = longint'({1'b1, fx}) * longint'({1'b1, fy});
      k = (p >= (longint'(1) << 47)) ? 47 : 46;
      sh = k - 23;
      q = p >> sh;
      rem = p - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      e = ex + ey - 127 + (k - 46);
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
      if (e >= 255) begin
        r.res = {s, 8'hFF, 23'd0};
        r.fl  = 4'b0101;
      end else if (e <= 0) begin
        r.res = {s, 31'd0};
        r.fl  = 4'b0011;
      end else begin
        r.res = {s, 8'(e), q[22:0]};
        r.fl  = {3'b000, rem != 0};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] genOperand();
    logic s;
    logic [7:0] e;
    logic [22:0] f;
    int c;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    c = $urandom_range(0, 9);
    case (c)
      0: e = 8'h00;
      1: begin e = 8'hFF; f = 23'd0; end
      2: begin e = 8'hFF; if (f == 23'd0) f = 23'd1; end
      3: e = 8'($urandom_range(200, 254));
      4: e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(64, 190));
    endcase
    return {s, e, f};
  endfunction

  // Drives one operand pair and records the expected response once the handshake completes.
  task automatic applyStimulus(input logic [31:0] aIn, input logic [31:0] bIn,
                               input logic [31:0] expRes, input logic [3:0] expFl);
    bit ok;
    exp_t item;
    a = aIn;
    b = bIn;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=in_ready_low required=accept");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    item.res = expRes;
    item.fl  = expFl;
    sbQ.push_back(item);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic applyRandom(input logic [31:0] aIn, input logic [31:0] bIn);
    exp_t m;
    m = refMul(aIn, bIn);
    applyStimulus(aIn, bIn, m.res, m.fl);
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (sbQ.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout actual=%0d_pending required=0", sbQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = randomReady ? ($urandom_range(0, 3) != 0) : forcedReady;
  end

  // Monitor: compare the presented result against the oldest expectation; pop on transfer.
  always @(negedge clk) begin
    exp_t head;
    if (monitorOn && rst_n) begin
      checkOutput("in_ready_rule", 36'(in_ready), 36'(!out_valid || out_ready));
      if (!in_ready) sawInReadyLow = 1'b1;
      if (out_valid) begin
        if (sbQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output actual=%h required=no_output", result);
        end else begin
          head = sbQ[0];
          checkOutput("result", 36'(result), 36'(head.res));
          checkOutput("flags", 36'(flags), 36'(head.fl));
          if (out_ready) head = sbQ.pop_front();
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] x, y;
    rst_n = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", 36'(out_valid), 36'(0));
    checkOutput("reset_result", 36'(result), 36'(0));
    checkOutput("reset_flags", 36'(flags), 36'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_reset", 36'(in_ready), 36'(1));
    monitorOn = 1'b1;

    $display("[TB] T1 basic product and latency");
    applyStimulus(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t1_latency", 36'(out_valid), 36'(k == 3));
    end
    waitDrain();

    $display("[TB] T2-T4 rounding, specials, range");
    applyStimulus(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    applyStimulus(32'hBF800000, 32'h3F800000, 32'hBF800000, 4'b0000);
    applyStimulus(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    applyStimulus(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000);
    applyStimulus(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
    applyStimulus(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
    applyStimulus(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    applyStimulus(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    applyStimulus(32'h80000000, 32'h40400000, 32'h80000000, 4'b0000);
    applyStimulus(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001);
    waitDrain();

    $display("[TB] T5 stalled stream");
    sawInReadyLow = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          x = 32'h3F800000 + (32'(i) << 19);
          y = 32'h40000000 + (32'(i) << 18) + 32'(i);
          applyRandom(x, y);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 forcedReady = 1'b0;
        repeat (5) @(posedge clk);
        #1 forcedReady = 1'b1;
      end
    join
    waitDrain();
    checkOutput("t5_in_ready_dropped", 36'(sawInReadyLow), 36'(1));

    $display("[TB] random operands with random backpressure");
    randomReady = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      applyRandom(genOperand(), genOperand());
    end
    randomReady = 1'b0;
    forcedReady = 1'b1;
    waitDrain();

    $display("[TB] T6 asynchronous reset with work in flight");
    forcedReady = 1'b0;
    applyRandom(32'h40400000, 32'h40400000);
    applyRandom(32'h3FC00000, 32'h3FC00000);
    applyRandom(32'h41000000, 32'h3E800000);
    @(posedge clk);
    #2;
    checkOutput("t6_valid_before_reset", 36'(out_valid), 36'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("t6_out_valid_async", 36'(out_valid), 36'(0));
    checkOutput("t6_result_async", 36'(result), 36'(0));
    checkOutput("t6_flags_async", 36'(flags), 36'(0));
    sbQ.delete();
    forcedReady = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
